// File: rtl/axis_mux_pkg.sv
// Shared constants for the two-input packet-aware AXI4-Stream multiplexer.
package axis_mux_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 8;
    localparam logic        SEL_IN0            = 1'b0;
    localparam logic        SEL_IN1            = 1'b1;

endpackage

// File: rtl/axis_skid_buffer.sv
// Full-throughput register slice: main register plus skid register, with a registered ready.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_payload,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_payload,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] skid_payload;
    logic             skid_valid;
    logic [WIDTH-1:0] main_payload_d;
    logic             main_valid_d;
    logic [WIDTH-1:0] skid_payload_d;
    logic             skid_valid_d;
    logic             s_fire;
    logic             m_fire;

    assign s_fire = s_valid & s_ready;
    assign m_fire = m_valid & m_ready;

    // Main register refills from skid first, then from the input; otherwise the input parks in skid.
    always_comb begin
        main_payload_d = m_payload;
        main_valid_d   = m_valid;
        skid_payload_d = skid_payload;
        skid_valid_d   = skid_valid;
        if (m_fire || !m_valid) begin
            if (skid_valid) begin
                main_payload_d = skid_payload;
                main_valid_d   = 1'b1;
                skid_valid_d   = 1'b0;
            end else begin
                if (s_fire) begin
                    main_payload_d = s_payload;
                end
                main_valid_d = s_fire;
            end
        end else if (s_fire) begin
            skid_payload_d = s_payload;
            skid_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_payload    <= '0;
            m_valid      <= 1'b0;
            skid_payload <= '0;
            skid_valid   <= 1'b0;
            s_ready      <= 1'b0;
        end else begin
            m_payload    <= main_payload_d;
            m_valid      <= main_valid_d;
            skid_payload <= skid_payload_d;
            skid_valid   <= skid_valid_d;
            s_ready      <= !skid_valid_d;
        end
    end

endmodule

// File: rtl/axis_mux_2to1.sv
// Two-input AXI4-Stream mux: grant follows sel between packets and is locked while a packet is open.
module axis_mux_2to1
    import axis_mux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [DATA_WIDTH-1:0] DATA_in_0,
    input  logic                  TVALID_in_0,
    input  logic                  TLAST_in_0,
    input  logic [DATA_WIDTH-1:0] DATA_in_1,
    input  logic                  TVALID_in_1,
    input  logic                  TLAST_in_1,
    input  logic                  sel,
    output logic                  TREADY_in,
    output logic [DATA_WIDTH-1:0] DATA_out,
    output logic                  TVALID_out,
    output logic                  TLAST_out,
    input  logic                  TREADY_out
);

    localparam int unsigned PAYLOAD_W = DATA_WIDTH + 1;

    logic                  gnt_q;
    logic                  pkt_open_q;
    logic                  gnt_c;
    logic                  in_valid_c;
    logic                  in_last_c;
    logic [DATA_WIDTH-1:0] in_data_c;
    logic                  accept_c;
    logic [PAYLOAD_W-1:0]  out_payload;

    // Between packets sel drives the grant directly in the same cycle.
    assign gnt_c = pkt_open_q ? gnt_q : sel;

    always_comb begin
        in_valid_c = TVALID_in_0;
        in_last_c  = TLAST_in_0;
        in_data_c  = DATA_in_0;
        if (gnt_c == SEL_IN1) begin
            in_valid_c = TVALID_in_1;
            in_last_c  = TLAST_in_1;
            in_data_c  = DATA_in_1;
        end
    end

    assign accept_c = TREADY_in & in_valid_c;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            gnt_q      <= SEL_IN0;
            pkt_open_q <= 1'b0;
        end else begin
            gnt_q <= gnt_c;
            if (accept_c) begin
                pkt_open_q <= !in_last_c;
            end
        end
    end

    axis_skid_buffer #(
        .WIDTH (PAYLOAD_W)
    ) u_out_slice (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .s_payload ({in_last_c, in_data_c}),
        .s_valid   (in_valid_c),
        .s_ready   (TREADY_in),
        .m_payload (out_payload),
        .m_valid   (TVALID_out),
        .m_ready   (TREADY_out)
    );

    assign TLAST_out = out_payload[PAYLOAD_W-1];
    assign DATA_out  = out_payload[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis_mux_2to1.sv
// Self-checking bench for axis_mux_2to1: directed scenarios plus a randomized run against a queue model.
`timescale 1ns/1ps
module tb_axis_mux_2to1;

    localparam int unsigned DW = 8;

    logic          ACLK;
    logic          ARESETn;
    logic [DW-1:0] DATA_in_0;
    logic          TVALID_in_0;
    logic          TLAST_in_0;
    logic [DW-1:0] DATA_in_1;
    logic          TVALID_in_1;
    logic          TLAST_in_1;
    logic          sel;
    logic          TREADY_in;
    logic [DW-1:0] DATA_out;
    logic          TVALID_out;
    logic          TLAST_out;
    logic          TREADY_out;

    axis_mux_2to1 #(.DATA_WIDTH(DW)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .DATA_in_0   (DATA_in_0),
        .TVALID_in_0 (TVALID_in_0),
        .TLAST_in_0  (TLAST_in_0),
        .DATA_in_1   (DATA_in_1),
        .TVALID_in_1 (TVALID_in_1),
        .TLAST_in_1  (TLAST_in_1),
        .sel         (sel),
        .TREADY_in   (TREADY_in),
        .DATA_out    (DATA_out),
        .TVALID_out  (TVALID_out),
        .TLAST_out   (TLAST_out),
        .TREADY_out  (TREADY_out)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int tests_run;
    int tests_failed;

    // Beats are {last, data}; sources hold pending beats, exp/obs hold accepted and delivered beats.
    bit [8:0] src0_q[$];
    bit [8:0] src1_q[$];
    bit [8:0] exp_q[$];
    bit [8:0] obs_q[$];
    int       acc_cyc_q[$];
    int       obs_cyc_q[$];

    bit       en0, en1, sel_cfg, rdy_cfg;
    bit       m_open, m_gnt, m_live;
    int       m_cnt;
    int       cyc;
    bit       hold_pending;
    bit [8:0] hold_val;
    int       n_rdy_err, n_vld_err, n_hold_err;
    bit       saw_rdy_low;

    task automatic clear_obs();
        exp_q.delete();
        obs_q.delete();
        acc_cyc_q.delete();
        obs_cyc_q.delete();
        n_rdy_err   = 0;
        n_vld_err   = 0;
        n_hold_err  = 0;
        saw_rdy_low = 1'b0;
    endtask

    // Called at a falling edge: observe outputs, drive inputs, predict the next rising edge, advance.
    task automatic tick();
        bit       g, acc, ofire, exp_rdy;
        bit [8:0] beat;
        exp_rdy = m_live && (m_cnt < 2);
        if (TREADY_in !== exp_rdy) n_rdy_err++;
        if (TVALID_out !== (m_cnt > 0)) n_vld_err++;
        if (hold_pending && ({TLAST_out, DATA_out} !== hold_val)) n_hold_err++;
        if (m_live && TREADY_in === 1'b0) saw_rdy_low = 1'b1;

        g           = m_open ? m_gnt : sel_cfg;
        sel         = sel_cfg;
        TREADY_out  = rdy_cfg;
        TVALID_in_0 = en0 && (src0_q.size() > 0);
        DATA_in_0   = (src0_q.size() > 0) ? src0_q[0][7:0] : 8'h00;
        TLAST_in_0  = (src0_q.size() > 0) ? src0_q[0][8] : 1'b0;
        TVALID_in_1 = en1 && (src1_q.size() > 0);
        DATA_in_1   = (src1_q.size() > 0) ? src1_q[0][7:0] : 8'h00;
        TLAST_in_1  = (src1_q.size() > 0) ? src1_q[0][8] : 1'b0;

        acc = (TREADY_in === 1'b1) && (g ? TVALID_in_1 : TVALID_in_0);
        if (acc) begin
            if (g) beat = src1_q.pop_front();
            else   beat = src0_q.pop_front();
            exp_q.push_back(beat);
            acc_cyc_q.push_back(cyc);
            m_open = !beat[8];
            m_gnt  = g;
        end
        ofire = (TVALID_out === 1'b1) && rdy_cfg;
        if (ofire) begin
            obs_q.push_back({TLAST_out, DATA_out});
            obs_cyc_q.push_back(cyc);
        end
        hold_pending = (TVALID_out === 1'b1) && !rdy_cfg;
        hold_val     = {TLAST_out, DATA_out};
        m_cnt        = m_cnt + int'(acc) - int'(ofire);
        m_live       = 1'b1;
        cyc++;
        @(negedge ACLK);
    endtask

    task automatic model_reset();
        src0_q.delete();
        src1_q.delete();
        clear_obs();
        en0 = 0; en1 = 0;
        TVALID_in_0 = 0; TVALID_in_1 = 0;
        m_open = 0; m_gnt = 0; m_cnt = 0; m_live = 0;
        hold_pending = 0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        model_reset();
        repeat (3) @(negedge ACLK);
        tests_run++;
        if (TVALID_out !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b expected 0", TVALID_out); end
        tests_run++;
        if (TLAST_out !== 1'b0) begin tests_failed++; $display("FAIL reset_tlast: got %b expected 0", TLAST_out); end
        tests_run++;
        if (DATA_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", DATA_out); end
        tests_run++;
        if (TREADY_in !== 1'b0) begin tests_failed++; $display("FAIL reset_tready: got %b expected 0", TREADY_in); end
        ARESETn = 1'b1;
        #1;
        tests_run++;
        if (TREADY_in !== 1'b0) begin tests_failed++; $display("FAIL release_tready_before_edge: got %b expected 0", TREADY_in); end
        @(negedge ACLK);
        tests_run++;
        if (TREADY_in !== 1'b1) begin tests_failed++; $display("FAIL release_tready_after_edge: got %b expected 1", TREADY_in); end
        tests_run++;
        if (TVALID_out !== 1'b0) begin tests_failed++; $display("FAIL release_tvalid_idle: got %b expected 0", TVALID_out); end
        m_live = 1'b1;
    endtask

    task automatic test_passthrough();
        bit [8:0]   want[3] = '{9'h011, 9'h022, 9'h133};
        logic [8:0] got;
        clear_obs();
        src0_q = '{9'h011, 9'h022, 9'h133};
        sel_cfg = 0; en0 = 1; en1 = 0; rdy_cfg = 1;
        repeat (8) tick();
        tests_run++;
        if (obs_q.size() != 3) begin tests_failed++; $display("FAIL pass_count: got %0d expected 3", obs_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 9'bx;
            tests_run++;
            if (got !== want[i]) begin tests_failed++; $display("FAIL pass_beat%0d: got %h expected %h", i, got, want[i]); end
        end
        tests_run++;
        if (obs_cyc_q.size() != 3 || acc_cyc_q.size() != 3 || obs_cyc_q[0] != acc_cyc_q[0] + 1 || obs_cyc_q[2] != obs_cyc_q[0] + 2) begin
            tests_failed++;
            $display("FAIL pass_latency: got first out cycle %0d, span %0d; expected accept+1 and span 2",
                     (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1,
                     (obs_cyc_q.size() > 2) ? obs_cyc_q[2] - obs_cyc_q[0] : -1);
        end
        tests_run++;
        if (n_rdy_err + n_vld_err != 0) begin tests_failed++; $display("FAIL pass_handshake: got %0d errors expected 0", n_rdy_err + n_vld_err); end
    endtask

    task automatic test_packet_lock();
        logic [8:0] got;
        bit   [8:0] want;
        int         guard;
        clear_obs();
        for (int i = 0; i < 16; i++) src1_q.push_back({(i == 15), 8'(8'h40 + i)});
        for (int i = 0; i < 4; i++)  src0_q.push_back({(i == 3), 8'(8'hA0 + i)});
        sel_cfg = 1; en0 = 1; en1 = 1; rdy_cfg = 1;
        guard = 0;
        while ((src0_q.size() > 0 || src1_q.size() > 0 || m_cnt > 0) && guard < 80) begin
            tick();
            if (exp_q.size() == 3) sel_cfg = 0;
            guard++;
        end
        tests_run++;
        if (guard >= 80) begin tests_failed++; $display("FAIL lock_timeout: got %0d cycles expected < 80", guard); end
        tests_run++;
        if (obs_q.size() != 20) begin tests_failed++; $display("FAIL lock_count: got %0d expected 20", obs_q.size()); end
        for (int i = 0; i < 20; i++) begin
            want = (i < 16) ? {(i == 15), 8'(8'h40 + i)} : {(i == 19), 8'(8'hA0 + i - 16)};
            got  = (i < obs_q.size()) ? obs_q[i] : 9'bx;
            tests_run++;
            if (got !== want) begin tests_failed++; $display("FAIL lock_beat%0d: got %h expected %h", i, got, want); end
        end
        tests_run++;
        if (acc_cyc_q.size() < 17 || acc_cyc_q[16] != acc_cyc_q[15] + 1) begin
            tests_failed++;
            $display("FAIL lock_switch_cycle: got gap %0d expected 1",
                     (acc_cyc_q.size() >= 17) ? acc_cyc_q[16] - acc_cyc_q[15] : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] got;
        bit   [8:0] want;
        clear_obs();
        for (int i = 1; i <= 8; i++) src0_q.push_back({(i == 8), 8'(i)});
        sel_cfg = 0; en0 = 1; en1 = 0;
        for (int k = 0; k < 20; k++) begin
            rdy_cfg = !(k >= 4 && k < 7);
            tick();
        end
        rdy_cfg = 1;
        tests_run++;
        if (saw_rdy_low !== 1'b1) begin tests_failed++; $display("FAIL bp_tready_drop: got %b expected 1", saw_rdy_low); end
        tests_run++;
        if (n_rdy_err != 0) begin tests_failed++; $display("FAIL bp_tready_timing: got %0d errors expected 0", n_rdy_err); end
        tests_run++;
        if (n_hold_err != 0) begin tests_failed++; $display("FAIL bp_hold: got %0d changes expected 0", n_hold_err); end
        tests_run++;
        if (obs_q.size() != 8) begin tests_failed++; $display("FAIL bp_count: got %0d expected 8", obs_q.size()); end
        for (int i = 0; i < 8; i++) begin
            want = {(i == 7), 8'(i + 1)};
            got  = (i < obs_q.size()) ? obs_q[i] : 9'bx;
            tests_run++;
            if (got !== want) begin tests_failed++; $display("FAIL bp_beat%0d: got %h expected %h", i, got, want); end
        end
    endtask

    task automatic test_both_valid();
        logic [8:0] got;
        bit   [8:0] want;
        clear_obs();
        for (int i = 0; i < 4; i++) src1_q.push_back({(i == 3), 8'(8'h81 + i)});
        for (int i = 0; i < 3; i++) src0_q.push_back({(i == 2), 8'(8'h01 + i)});
        sel_cfg = 1; en0 = 1; en1 = 1; rdy_cfg = 1;
        repeat (10) tick();
        tests_run++;
        if (obs_q.size() != 4) begin tests_failed++; $display("FAIL both_count: got %0d expected 4", obs_q.size()); end
        for (int i = 0; i < 4; i++) begin
            want = {(i == 3), 8'(8'h81 + i)};
            got  = (i < obs_q.size()) ? obs_q[i] : 9'bx;
            tests_run++;
            if (got !== want) begin tests_failed++; $display("FAIL both_beat%0d: got %h expected %h", i, got, want); end
        end
        en1 = 0;
        repeat (6) tick();
        tests_run++;
        if (TVALID_out !== 1'b0) begin tests_failed++; $display("FAIL ignored_tvalid: got %b expected 0", TVALID_out); end
        tests_run++;
        if (obs_q.size() != 4 || src0_q.size() != 3) begin
            tests_failed++;
            $display("FAIL ignored_consumed: got out %0d src0 left %0d expected 4 and 3", obs_q.size(), src0_q.size());
        end
        sel_cfg = 0;
        repeat (8) tick();
        tests_run++;
        if (n_rdy_err + n_vld_err != 0) begin tests_failed++; $display("FAIL both_handshake: got %0d errors expected 0", n_rdy_err + n_vld_err); end
    endtask

    task automatic test_reset_mid();
        int guard;
        clear_obs();
        for (int i = 0; i < 6; i++) src1_q.push_back({(i == 5), 8'(8'hD0 + i)});
        sel_cfg = 1; en0 = 0; en1 = 1; rdy_cfg = 0;
        guard = 0;
        while (!(m_cnt == 2 && m_open) && guard < 20) begin
            tick();
            guard++;
        end
        tests_run++;
        if (guard >= 20) begin tests_failed++; $display("FAIL rstmid_fill_timeout: got %0d cycles expected < 20", guard); end
        #2 ARESETn = 1'b0;
        #1;
        tests_run++;
        if (TVALID_out !== 1'b0) begin tests_failed++; $display("FAIL rstmid_tvalid: got %b expected 0", TVALID_out); end
        tests_run++;
        if (TREADY_in !== 1'b0 || DATA_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL rstmid_clear: got tready %b data %h expected 0 and 00", TREADY_in, DATA_out);
        end
        model_reset();
        @(negedge ACLK);
        ARESETn = 1'b1;
        src0_q.push_back(9'h1C1);
        src1_q.push_back(9'h1E0);
        sel_cfg = 0; en0 = 1; en1 = 1; rdy_cfg = 1;
        repeat (6) tick();
        tests_run++;
        if (obs_q.size() < 1 || obs_q[0] !== 9'h1C1) begin
            tests_failed++;
            $display("FAIL rstmid_first_beat: got %h expected 1c1", (obs_q.size() > 0) ? obs_q[0] : 9'h000);
        end
        sel_cfg = 1;
        repeat (6) tick();
        tests_run++;
        if (n_rdy_err + n_vld_err != 0) begin tests_failed++; $display("FAIL rstmid_handshake: got %0d errors expected 0", n_rdy_err + n_vld_err); end
    endtask

    task automatic test_random();
        bit [8:0] gen0[$];
        bit [8:0] gen1[$];
        bit [8:0] out0[$];
        bit [8:0] out1[$];
        int       guard, bad, interleave;
        bit       in_pkt, pkt_src;
        clear_obs();
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 10; p++) begin
                int len = int'($urandom_range(1, 5));
                for (int b = 0; b < len; b++) begin
                    bit [8:0] v;
                    v = {(b == len - 1), 1'(s), 7'($urandom)};
                    if (s == 0) begin src0_q.push_back(v); gen0.push_back(v); end
                    else        begin src1_q.push_back(v); gen1.push_back(v); end
                end
            end
        end
        guard = 0;
        while ((src0_q.size() > 0 || src1_q.size() > 0 || m_cnt > 0) && guard < 3000) begin
            sel_cfg = 1'($urandom_range(0, 1));
            en0     = ($urandom_range(0, 3) != 0);
            en1     = ($urandom_range(0, 3) != 0);
            rdy_cfg = ($urandom_range(0, 2) != 0);
            tick();
            guard++;
        end
        rdy_cfg = 1;
        tests_run++;
        if (guard >= 3000) begin tests_failed++; $display("FAIL rand_timeout: got %0d cycles expected < 3000", guard); end
        tests_run++;
        if (obs_q.size() != gen0.size() + gen1.size()) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), gen0.size() + gen1.size());
        end
        bad = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (i >= exp_q.size() || obs_q[i] !== exp_q[i]) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL rand_scoreboard: got %0d differing beats expected 0", bad); end
        interleave = 0;
        in_pkt = 0;
        pkt_src = 0;
        foreach (obs_q[i]) begin
            if (!in_pkt) pkt_src = obs_q[i][7];
            else if (obs_q[i][7] != pkt_src) interleave++;
            in_pkt = !obs_q[i][8];
            if (obs_q[i][7]) out1.push_back(obs_q[i]);
            else             out0.push_back(obs_q[i]);
        end
        tests_run++;
        if (interleave != 0) begin tests_failed++; $display("FAIL rand_interleave: got %0d foreign beats expected 0", interleave); end
        tests_run++;
        if (out0 != gen0 || out1 != gen1) begin
            tests_failed++;
            $display("FAIL rand_source_order: got %0d/%0d beats expected %0d/%0d in order",
                     out0.size(), out1.size(), gen0.size(), gen1.size());
        end
        tests_run++;
        if (n_rdy_err + n_vld_err + n_hold_err != 0) begin
            tests_failed++;
            $display("FAIL rand_protocol: got rdy %0d vld %0d hold %0d errors expected 0", n_rdy_err, n_vld_err, n_hold_err);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        sel = 0; TREADY_out = 0;
        DATA_in_0 = 0; TLAST_in_0 = 0; DATA_in_1 = 0; TLAST_in_1 = 0;
        sel_cfg = 0; rdy_cfg = 0;
        test_reset();
        test_passthrough();
        test_packet_lock();
        test_backpressure();
        test_both_valid();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit reached expected run to complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_mux_2to1.md
Name: axis_mux_2to1

Overview:
- Two-input AXI4-Stream multiplexer with a packet-aware grant and a registered output stage.
- It forwards one of two upstream streams (input 0 or input 1) to a single downstream stream, chosen by `sel`.
- The grant is only changed on packet boundaries, so packets are never interleaved.
- It sits between two stream producers and one consumer; the output stage is a full-throughput register slice.

Parameters:
- DATA_WIDTH, 8, width of DATA_in_0, DATA_in_1 and DATA_out.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- DATA_in_0  in  DATA_WIDTH  input 0 TDATA.
- TVALID_in_0  in  1  input 0 TVALID.
- TLAST_in_0  in  1  input 0 TLAST.
- DATA_in_1  in  DATA_WIDTH  input 1 TDATA.
- TVALID_in_1  in  1  input 1 TVALID.
- TLAST_in_1  in  1  input 1 TLAST.
- sel  in  1  requested source: 0 = input 0, 1 = input 1.
- TREADY_in  out  1  TREADY to the granted input; high means a beat from the granted input is accepted this cycle.
- DATA_out  out  DATA_WIDTH  output TDATA.
- TVALID_out  out  1  output TVALID.
- TLAST_out  out  1  output TLAST.
- TREADY_out  in  1  TREADY from downstream.

Behaviour:
- Clock/reset: single clock ACLK; ARESETn is asynchronous, active-low.
- Reset values:
  - TVALID_out = 0, TLAST_out = 0, DATA_out = 0, TREADY_in = 0.
  - Grant = input 0; packet-in-progress flag = 0; skid register empty.
- After reset release: TREADY_in rises on the first ACLK edge after ARESETn goes high.
- Grant:
  - `gnt` is a register. While no packet is in progress, `gnt` = `sel` combinationally, and that value is used in the same cycle.
  - When a beat from the granted input is accepted with TLAST = 0, the packet-in-progress flag sets and `gnt` freezes. Changes on `sel` are then ignored.
  - The flag clears on acceptance of a beat with TLAST = 1 from the granted input. `sel` is sampled again from the next cycle.
  - A single-beat packet (TLAST = 1 on its first beat) never sets the flag.
- Input acceptance:
  - Accept = TREADY_in & TVALID_in_<gnt>.
  - The non-granted input's TVALID, DATA and TLAST are ignored entirely; none of its beats are consumed.
  - Upstream sources must qualify TREADY_in with the grant.
- Output stage (register slice: main register plus skid register):
  - TREADY_in = skid register empty (registered; no combinational path from TREADY_out).
  - Latency: an accepted beat appears on DATA_out/TLAST_out with TVALID_out = 1 on the next cycle.
  - Output transfer = TVALID_out & TREADY_out.
  - Main register empty, or transferring this cycle: the incoming beat loads the main register.
  - Otherwise: the incoming beat loads the skid register, and TREADY_in drops next cycle.
  - When the main register transfers and the skid register is full: skid moves to main and TREADY_in rises next cycle.
  - Throughput: 1 beat/cycle while TREADY_out = 1.
  - AXI stability: while TVALID_out = 1 and TREADY_out = 0, DATA_out and TLAST_out hold.
  - TVALID_out never drops without a transfer.
  - No beat is dropped or duplicated.
- Boundary conditions:
  - Both TVALIDs high: only the granted input moves.
  - `sel` toggles mid-packet: no effect until TLAST is accepted.
  - TREADY_out held low: at most 2 beats are buffered, then TREADY_in = 0.
  - Reset mid-packet: all state is cleared immediately and buffered beats are discarded; the grant returns to input 0.

Decomposition:
- Shared package `axis_mux_pkg`: DATA_WIDTH default; constants SEL_IN0 = 1'b0 and SEL_IN1 = 1'b1.
- Sub-module `axis_skid_buffer` (DATA_WIDTH + 1 bits payload: data and last). It implements the register-slice output stage.
- The top level contains the grant/lock logic and the input mux.

Test Plan:
- Reset: hold ARESETn = 0 for any duration -> all outputs 0. Release -> TREADY_in = 1 after the first ACLK edge; TVALID_out stays 0 with no input valid.
- Pass-through on input 0: sel = 0, TVALID_in_0 = 1 with data 0x11, 0x22, 0x33, TLAST on 0x33, TREADY_out = 1 -> DATA_out 0x11, 0x22, 0x33 on consecutive cycles starting one cycle after the first accept, with TLAST_out = 1 on 0x33 only.
- Packet lock: input 1 packet of 16 beats starting at 0x40; `sel` switched to 0 after beat 3 while TVALID_in_0 = 1 -> all 16 beats of input 1 are output first, with no input 0 data interleaved. Input 0 data follows starting the cycle after the TLAST accept.
- Backpressure: stream 0x01..0x08 on input 0; TREADY_out = 0 for 3 cycles mid-stream -> TREADY_in drops after 2 buffered beats, DATA_out is held stable, and the output sequence 0x01..0x08 is complete, in order, with no duplicates.
- Both valid / ignored input: TVALID_in_0 = TVALID_in_1 = 1, sel = 1 -> only input 1 beats appear. TVALID_in_1 = 0 while TVALID_in_0 = 1, sel = 1 -> TVALID_out goes low and no input 0 beats appear.
- Reset mid-packet: assert ARESETn = 0 while 2 beats are buffered and a packet is open -> TVALID_out = 0 immediately. After release, with sel = 0, the next output beat comes from input 0.
